pb_debouncer: RTL and testbench

Synchronizes and debounces a raw mechanical push-button input. Produces a clean level (`pbOut`) that drives the single-pulse generator's `clkPb` input directly. Also produces one-cycle press and release event strobes. It sits between the board pin and the one-pulser, so the one-pulser only ever sees a glitch-free, clock-domain-safe signal.

---
 rtl/pb_debouncer.sv | 74 +++++++
 tb/tb_pb_debouncer.sv | 113 +++++++++++
 2 files changed

// File: rtl/pb_debouncer.sv
// pb_debouncer: two-flop synchronizer plus four-state debounce FSM with press/release strobes
module pb_debouncer #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic pbIn,
  output logic pbOut,
  output logic pressEv,
  output logic releaseEv
);
  typedef enum logic [1:0] {LOW, DEB_H, HIGH, DEB_L} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
  logic s1, s2;
  state_t state;
  logic [CNT_W-1:0] cnt;
  // bring the asynchronous pin into the clk domain; only s2 is used downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pbIn;
      s2 <= s1;
    end
  end
  // accept a level only after DB_CYCLES consecutive stable samples; any disagreement restarts the window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOW;
      cnt       <= '0;
      pbOut     <= 1'b0;
      pressEv   <= 1'b0;
      releaseEv <= 1'b0;
    end else begin
      pressEv   <= 1'b0;
      releaseEv <= 1'b0;
      case (state)
        LOW: if (s2) begin
          state <= DEB_H;
          cnt   <= '0;
        end
        DEB_H: if (!s2) begin
          state <= LOW;
          cnt   <= '0;
        end else if (cnt == LAST) begin
          state   <= HIGH;
          cnt     <= '0;
          pbOut   <= 1'b1;
          pressEv <= 1'b1;
        end else cnt <= cnt + CNT_W'(1);
        HIGH: if (!s2) begin
          state <= DEB_L;
          cnt   <= '0;
        end
        DEB_L: if (s2) begin
          state <= HIGH;
          cnt   <= '0;
        end else if (cnt == LAST) begin
          state     <= LOW;
          cnt       <= '0;
          pbOut     <= 1'b0;
          releaseEv <= 1'b1;
        end else cnt <= cnt + CNT_W'(1);
        default: begin
          state <= LOW;
          cnt   <= '0;
          pbOut <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pb_debouncer.sv
// tb_pb_debouncer: per-edge vector table with scoreboard queue plus hand-written reset and downstream checks
module tb_pb_debouncer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pbIn = 1'b0;
  logic pbOut, pressEv, releaseEv;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic pb;
    logic rn;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[$];
  logic [2:0] sb[$];
  int n_clk_en = 0, n_press = 0, n_release = 0, n_both = 0;
  logic prev_out = 1'b0;

  pb_debouncer #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .pbIn(pbIn),
    .pbOut(pbOut), .pressEv(pressEv), .releaseEv(releaseEv)
  );

  always #5 clk = ~clk;

  // one-pulser model downstream of pbOut plus strobe counters
  always @(posedge clk) begin
    #1;
    if (pbOut && !prev_out) n_clk_en++;
    prev_out = pbOut;
    if (pressEv) n_press++;
    if (releaseEv) n_release++;
    if (pressEv && releaseEv) n_both++;
  end

  task automatic add(input int n, input logic pb, input logic rn, input logic eo, input logic ep, input logic er);
    for (int i = 0; i < n; i++) vecs.push_back('{pb, rn, {eo, ep, er}});
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  initial begin
    logic [2:0] e;
    int first, cnt;
    // reset
    add(2, 0, 0, 0, 0, 0);
    // clean press
    add(6, 1, 1, 0, 0, 0); add(1, 1, 1, 1, 1, 0); add(2, 1, 1, 1, 0, 0);
    // clean release
    add(6, 0, 1, 1, 0, 0); add(1, 0, 1, 0, 0, 1); add(2, 0, 1, 0, 0, 0);
    // glitch rejection
    add(3, 1, 1, 0, 0, 0); add(8, 0, 1, 0, 0, 0);
    // bouncy press 1,0,1,1,0 then held
    add(1, 1, 1, 0, 0, 0); add(1, 0, 1, 0, 0, 0); add(2, 1, 1, 0, 0, 0); add(1, 0, 1, 0, 0, 0);
    add(6, 1, 1, 0, 0, 0); add(1, 1, 1, 1, 1, 0); add(2, 1, 1, 1, 0, 0);
    // release
    add(6, 0, 1, 1, 0, 0); add(1, 0, 1, 0, 0, 1); add(2, 0, 1, 0, 0, 0);
    // reset mid-debounce, button held through reset
    add(4, 1, 1, 0, 0, 0); add(2, 1, 0, 0, 0, 0);
    add(6, 1, 1, 0, 0, 0); add(1, 1, 1, 1, 1, 0); add(2, 1, 1, 1, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      pbIn = vecs[i].pb;
      rst  = vecs[i].rn;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pbOut, pressEv, releaseEv} != e) begin
        errors++;
        $display("FAIL vec%0d {pbOut,pressEv,releaseEv}: got %b expected %b", i, {pbOut, pressEv, releaseEv}, e);
      end
    end

    // asynchronous reset while HIGH clears outputs without a clock edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", int'({pbOut, pressEv, releaseEv}), 0);
    @(negedge clk);
    rst = 1'b1;
    first = -1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (pressEv) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check("held_press_latency", first, 6);
    check("held_press_count", cnt, 1);
    check("held_pbOut", int'(pbOut), 1);

    // downstream one-pulser and strobe totals
    check("clk_en_pulses", n_clk_en, 4);
    check("press_total", n_press, 4);
    check("release_total", n_release, 2);
    check("strobes_together", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
